// File: rtl/gfx256_pkg.sv
// Shared types for the gfx256 pixel pipeline.
// Clip/z-cull state encoding and depth-compare helper.
package gfx256_pkg;

  typedef enum logic [1:0] {
    CZ_IDLE,
    CZ_ZRD,
    CZ_ZWR,
    CZ_OUT
  } clip_zq_state_e;

  typedef enum logic [2:0] {
    ZF_NEVER,
    ZF_LESS,
    ZF_LEQUAL,
    ZF_EQUAL,
    ZF_GREATER,
    ZF_GEQUAL,
    ZF_NOTEQUAL,
    ZF_ALWAYS
  } z_func_t;

  function automatic logic fnZCompare(
    input z_func_t           func,
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic r;
    r = 1'b0;
    unique case (func)
      ZF_NEVER:    r = 1'b0;
      ZF_LESS:     r = (a < b);
      ZF_LEQUAL:   r = (a <= b);
      ZF_EQUAL:    r = (a == b);
      ZF_GREATER:  r = (a > b);
      ZF_GEQUAL:   r = (a >= b);
      ZF_NOTEQUAL: r = (a != b);
      ZF_ALWAYS:   r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gfx256_zlane_rmw.sv
// Depth lane extract/insert and byte-select generation
// over one 256-bit z-buffer line.
module gfx256_zlane_rmw
  import gfx256_pkg::*;
#(
  parameter int Z_W = 16
) (
  input  logic [4:0]     lane_i,
  input  logic [255:0]   line_i,
  input  logic [Z_W-1:0] z_i,
  output logic [Z_W-1:0] z_o,
  output logic [255:0]   line_o,
  output logic [31:0]    sel_o
);
  localparam int ZB = Z_W / 8;

  logic [7:0]   sh;
  logic [255:0] shr;
  logic [255:0] mask;
  logic [255:0] ins;

  assign sh     = {lane_i, 3'b000};
  assign shr    = line_i >> sh;
  assign z_o    = shr[Z_W-1:0];
  assign mask   = {{(256-Z_W){1'b0}}, {Z_W{1'b1}}} << sh;
  assign ins    = {{(256-Z_W){1'b0}}, z_i} << sh;
  assign line_o = (line_i & ~mask) | ins;
  assign sel_o  = {{(32-ZB){1'b0}}, {ZB{1'b1}}} << lane_i;

endmodule

// File: rtl/gfx256_clip_zq.sv
// Per-pixel rect clip and depth test with z-buffer
// read-modify-write and saturating discard statistics.
module gfx256_clip_zq
  import gfx256_pkg::*;
#(
  parameter int POINT_W = 16,
  parameter int Z_W     = 16,
  parameter int CNT_W   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clip_en_i,
  input  logic                    z_en_i,
  input  logic                    z_wen_i,
  input  logic [2:0]              z_func_i,
  input  logic [31:5]             zbuffer_base_i,
  input  logic [POINT_W-1:0]      target_size_x_i,
  input  logic [POINT_W-1:0]      target_x0_i,
  input  logic [POINT_W-1:0]      target_y0_i,
  input  logic [POINT_W-1:0]      target_x1_i,
  input  logic [POINT_W-1:0]      target_y1_i,
  input  logic [POINT_W-1:0]      clip_x0_i,
  input  logic [POINT_W-1:0]      clip_y0_i,
  input  logic [POINT_W-1:0]      clip_x1_i,
  input  logic [POINT_W-1:0]      clip_y1_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_src_i,
  input  logic [POINT_W-1:0]      in_x_i,
  input  logic [POINT_W-1:0]      in_y_i,
  input  logic [POINT_W-1:0]      in_u_i,
  input  logic [POINT_W-1:0]      in_v_i,
  input  logic signed [Z_W-1:0]   in_z_i,
  input  logic [7:0]              in_a_i,
  input  logic [31:0]             in_color_i,
  output logic                    z_rd_req_o,
  output logic                    z_wr_req_o,
  input  logic                    z_ack_i,
  input  logic                    wbm_busy_i,
  output logic [31:5]             z_addr_o,
  output logic [31:0]             z_sel_o,
  input  logic [255:0]            z_data_i,
  output logic [255:0]            z_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [POINT_W-1:0]      pixel_x_o,
  output logic [POINT_W-1:0]      pixel_y_o,
  output logic [POINT_W-1:0]      u_o,
  output logic [POINT_W-1:0]      v_o,
  output logic [Z_W-1:0]          pixel_z_o,
  output logic [7:0]              a_o,
  output logic [31:0]             color_o,
  input  logic                    clr_stats_i,
  output logic [CNT_W-1:0]        clip_cnt_o,
  output logic [CNT_W-1:0]        zfail_cnt_o,
  output logic [CNT_W-1:0]        pass_cnt_o
);
  localparam int ZB = Z_W / 8;

  clip_zq_state_e     state_q, state_d;
  logic [POINT_W-1:0] x_q, x_d, y_q, y_d;
  logic [POINT_W-1:0] u_q, u_d, v_q, v_d;
  logic [Z_W-1:0]     z_q, z_d;
  logic [7:0]         a_q, a_d;
  logic [31:0]        color_q, color_d;
  logic [31:5]        addr_q, addr_d;
  logic [4:0]         lane_q, lane_d;
  logic [255:0]       line_q, line_d;
  logic               drop_q, drop_d;
  logic               rd_hold_q, rd_hold_d;
  logic               wr_hold_q, wr_hold_d;
  logic [CNT_W-1:0]   clip_q, clip_d;
  logic [CNT_W-1:0]   zfail_q, zfail_d;
  logic [CNT_W-1:0]   pass_q, pass_d;

  logic         in_zrd, in_zwr;
  logic         accept, discard, in_tgt, in_clip;
  logic         rd_ack, wr_ack, z_pass;
  logic         clip_inc, zfail_inc, pass_inc;
  logic [31:0]  pix, off;
  logic [Z_W-1:0] stored;
  logic [255:0] rmw_line;
  logic [31:0]  rmw_sel;

  assign in_zrd     = (state_q == CZ_ZRD);
  assign in_zwr     = (state_q == CZ_ZWR);
  assign in_ready_o = (state_q == CZ_IDLE) && !drop_q;
  assign accept     = in_valid_i && in_ready_o;

  assign in_tgt = (in_x_i >= target_x0_i) && (in_x_i < target_x1_i) &&
                  (in_y_i >= target_y0_i) && (in_y_i < target_y1_i);
  assign in_clip = (in_x_i >= clip_x0_i) && (in_x_i < clip_x1_i) &&
                   (in_y_i >= clip_y0_i) && (in_y_i < clip_y1_i);
  assign discard = !in_tgt || (clip_en_i && !in_clip);

  assign pix = 32'(in_y_i) * 32'(target_size_x_i) + 32'(in_x_i);
  assign off = pix * 32'(ZB);

  // Requests latch high once raised so a late busy cannot retract them.
  assign z_rd_req_o = in_zrd && (rd_hold_q || !wbm_busy_i);
  assign z_wr_req_o = in_zwr && (wr_hold_q || !wbm_busy_i);
  assign rd_ack     = z_rd_req_o && z_ack_i;
  assign wr_ack     = z_wr_req_o && z_ack_i;

  gfx256_zlane_rmw #(.Z_W(Z_W)) u_rmw (
    .lane_i (lane_q),
    .line_i (in_zrd ? z_data_i : line_q),
    .z_i    (z_q),
    .z_o    (stored),
    .line_o (rmw_line),
    .sel_o  (rmw_sel)
  );

  assign z_pass = fnZCompare(z_func_t'(z_func_i),
                             32'(signed'(z_q)),
                             32'(signed'(stored)));

  assign z_addr_o    = addr_q;
  assign z_sel_o     = (in_zrd || in_zwr) ? rmw_sel : 32'd0;
  assign z_data_o    = rmw_line;
  assign out_valid_o = (state_q == CZ_OUT);
  assign pixel_x_o   = x_q;
  assign pixel_y_o   = y_q;
  assign u_o         = u_q;
  assign v_o         = v_q;
  assign pixel_z_o   = z_q;
  assign a_o         = a_q;
  assign color_o     = color_q;
  assign clip_cnt_o  = clip_q;
  assign zfail_cnt_o = zfail_q;
  assign pass_cnt_o  = pass_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    u_d       = u_q;
    v_d       = v_q;
    z_d       = z_q;
    a_d       = a_q;
    color_d   = color_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    line_d    = line_q;
    drop_d    = 1'b0;
    rd_hold_d = z_rd_req_o && !z_ack_i;
    wr_hold_d = z_wr_req_o && !z_ack_i;
    clip_inc  = 1'b0;
    zfail_inc = 1'b0;
    pass_inc  = 1'b0;
    unique case (state_q)
      CZ_IDLE: begin
        if (accept) begin
          x_d     = in_x_i;
          y_d     = in_y_i;
          u_d     = in_u_i;
          v_d     = in_v_i;
          z_d     = in_src_i ? in_z_i : '0;
          a_d     = in_src_i ? in_a_i : 8'hFF;
          color_d = in_color_i;
          addr_d  = zbuffer_base_i + off[31:5];
          lane_d  = off[4:0];
          if (discard) begin
            drop_d   = 1'b1;
            clip_inc = 1'b1;
          end else if (in_src_i && z_en_i) begin
            state_d = CZ_ZRD;
          end else begin
            state_d = CZ_OUT;
          end
        end
      end
      CZ_ZRD: begin
        if (rd_ack) begin
          line_d = z_data_i;
          if (!z_pass) begin
            zfail_inc = 1'b1;
            state_d   = CZ_IDLE;
          end else begin
            state_d = z_wen_i ? CZ_ZWR : CZ_OUT;
          end
        end
      end
      CZ_ZWR: begin
        if (wr_ack) state_d = CZ_OUT;
      end
      CZ_OUT: begin
        if (out_ready_i) begin
          pass_inc = 1'b1;
          state_d  = CZ_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    clip_d  = clip_q;
    zfail_d = zfail_q;
    pass_d  = pass_q;
    if (clr_stats_i) begin
      clip_d  = '0;
      zfail_d = '0;
      pass_d  = '0;
    end else begin
      if (clip_inc && !(&clip_q))   clip_d  = clip_q + CNT_W'(1);
      if (zfail_inc && !(&zfail_q)) zfail_d = zfail_q + CNT_W'(1);
      if (pass_inc && !(&pass_q))   pass_d  = pass_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CZ_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      u_q       <= '0;
      v_q       <= '0;
      z_q       <= '0;
      a_q       <= '0;
      color_q   <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      line_q    <= '0;
      drop_q    <= 1'b0;
      rd_hold_q <= 1'b0;
      wr_hold_q <= 1'b0;
      clip_q    <= '0;
      zfail_q   <= '0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      u_q       <= u_d;
      v_q       <= v_d;
      z_q       <= z_d;
      a_q       <= a_d;
      color_q   <= color_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      line_q    <= line_d;
      drop_q    <= drop_d;
      rd_hold_q <= rd_hold_d;
      wr_hold_q <= wr_hold_d;
      clip_q    <= clip_d;
      zfail_q   <= zfail_d;
      pass_q    <= pass_d;
    end
  end

endmodule

// File: tb/tb_gfx256_clip_zq.sv
// Bench for gfx256_clip_zq: directed scenarios plus random
// pixels against a pixel-indexed z-buffer reference model.
module tb_gfx256_clip_zq;
  localparam int PW  = 16;
  localparam int ZW  = 16;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clip_en = 1'b0, z_en = 1'b0, z_wen = 1'b0;
  logic [2:0] z_func = 3'd0;
  logic [31:5] zbase = 27'h100;
  logic [PW-1:0] pitch = 16'd640;
  logic [PW-1:0] tx0 = 0, ty0 = 0, tx1 = 16'd640, ty1 = 16'd480;
  logic [PW-1:0] cx0 = 0, cy0 = 0, cx1 = 0, cy1 = 0;
  logic in_valid = 1'b0, in_src = 1'b0;
  logic [PW-1:0] in_x = 0, in_y = 0, in_u = 0, in_v = 0;
  logic [ZW-1:0] in_z = 0;
  logic [7:0] in_a = 0;
  logic [31:0] in_color = 0;
  logic z_ack = 1'b0, wbm_busy = 1'b0;
  logic [255:0] z_data = '0;
  logic out_ready = 1'b0, clr = 1'b0;

  logic in_ready, z_rd_req, z_wr_req, out_valid;
  logic [31:5] z_addr;
  logic [31:0] z_sel;
  logic [255:0] z_wdata;
  logic [PW-1:0] px_x, px_y, px_u, px_v;
  logic [ZW-1:0] px_z;
  logic [7:0] px_a;
  logic [31:0] px_col;
  logic [CW-1:0] clip_cnt, zfail_cnt, pass_cnt;

  gfx256_clip_zq #(.POINT_W(PW), .Z_W(ZW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .clip_en_i(clip_en), .z_en_i(z_en), .z_wen_i(z_wen),
    .z_func_i(z_func), .zbuffer_base_i(zbase),
    .target_size_x_i(pitch),
    .target_x0_i(tx0), .target_y0_i(ty0),
    .target_x1_i(tx1), .target_y1_i(ty1),
    .clip_x0_i(cx0), .clip_y0_i(cy0),
    .clip_x1_i(cx1), .clip_y1_i(cy1),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_src_i(in_src), .in_x_i(in_x), .in_y_i(in_y),
    .in_u_i(in_u), .in_v_i(in_v), .in_z_i(in_z),
    .in_a_i(in_a), .in_color_i(in_color),
    .z_rd_req_o(z_rd_req), .z_wr_req_o(z_wr_req),
    .z_ack_i(z_ack), .wbm_busy_i(wbm_busy),
    .z_addr_o(z_addr), .z_sel_o(z_sel),
    .z_data_i(z_data), .z_data_o(z_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pixel_x_o(px_x), .pixel_y_o(px_y),
    .u_o(px_u), .v_o(px_v), .pixel_z_o(px_z),
    .a_o(px_a), .color_o(px_col),
    .clr_stats_i(clr),
    .clip_cnt_o(clip_cnt), .zfail_cnt_o(zfail_cnt),
    .pass_cnt_o(pass_cnt)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  int m_clip = 0, m_zfail = 0, m_pass = 0;

  bit s_src;
  int s_x, s_y, s_u, s_v, s_z, s_a;
  logic [31:0] s_color;

  int o_kind, o_lat, o_rdy_low, o_gap;
  bit o_rd, o_wr, o_both;
  logic [31:5] o_addr;
  logic [31:0] o_sel;
  logic [255:0] o_wdata;
  logic [PW-1:0] o_x, o_y, o_u, o_v;
  logic [ZW-1:0] o_z;
  logic [7:0] o_a;
  logic [31:0] o_col;

  // Reference z-buffer, one entry per pixel index.
  shortint zbuf[int];

  function automatic int zget(input int idx);
    if (zbuf.exists(idx)) return int'(zbuf[idx]);
    return (idx * 7) % 17 - 8;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:5] a);
    logic [255:0] l;
    int base;
    base = int'(a - zbase) * 16;
    for (int k = 0; k < 16; k++) l[k*16 +: 16] = 16'(zget(base + k));
    return l;
  endfunction

  task automatic store_line(input logic [31:5] a, input logic [255:0] d);
    int base;
    base = int'(a - zbase) * 16;
    for (int k = 0; k < 16; k++) zbuf[base + k] = shortint'(d[k*16 +: 16]);
  endtask

  function automatic bit m_cmp(input int f, input int a, input int b);
    case (f)
      0: return 1'b0;
      1: return a < b;
      2: return a <= b;
      3: return a == b;
      4: return a > b;
      5: return a >= b;
      6: return a != b;
      default: return 1'b1;
    endcase
  endfunction

  // 0 = reaches output, 1 = clipped, 2 = depth fail
  function automatic int m_code();
    bit it, ic;
    it = s_x >= int'(tx0) && s_x < int'(tx1) && s_y >= int'(ty0) && s_y < int'(ty1);
    ic = s_x >= int'(cx0) && s_x < int'(cx1) && s_y >= int'(cy0) && s_y < int'(cy1);
    if (!it || (clip_en && !ic)) return 1;
    if (s_src && z_en && !m_cmp(int'(z_func), s_z, zget(s_y * int'(pitch) + s_x)))
      return 2;
    return 0;
  endfunction

  task automatic m_count(input int code);
    if (code == 1 && m_clip < SAT) m_clip++;
    if (code == 2 && m_zfail < SAT) m_zfail++;
    if (code == 0 && m_pass < SAT) m_pass++;
  endtask

  task automatic setpix(input bit src, input int x, input int y, input int z);
    s_src = src; s_x = x; s_y = y; s_z = z;
    s_u = int'($urandom_range(0, 65535));
    s_v = int'($urandom_range(0, 65535));
    s_a = int'($urandom_range(0, 255));
    s_color = $urandom;
  endtask

  // Offer one pixel, act as bus slave and sink, record what happened.
  task automatic run_pixel(input int rd_wait, input int wr_busy);
    int rw, rd_ack_n;
    bit done;
    o_kind = 0; o_lat = 0; o_rdy_low = 0; o_gap = 0;
    o_rd = 0; o_wr = 0; o_both = 0;
    o_addr = '0; o_sel = '0; o_wdata = '0;
    rw = rd_wait; rd_ack_n = -1000; done = 0;
    in_src = s_src; in_x = 16'(s_x); in_y = 16'(s_y);
    in_u = 16'(s_u); in_v = 16'(s_v); in_z = 16'(s_z);
    in_a = 8'(s_a); in_color = s_color;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      wbm_busy = (c - rd_ack_n) >= 1 && (c - rd_ack_n) <= wr_busy;
      #1;
      if (z_rd_req && z_wr_req) o_both = 1;
      if (!in_ready) o_rdy_low++;
      if (out_valid) begin
        o_kind = 1; o_lat = c;
        o_x = px_x; o_y = px_y; o_u = px_u; o_v = px_v;
        o_z = px_z; o_a = px_a; o_col = px_col;
        out_ready = 1'b1; done = 1;
      end else if (z_rd_req) begin
        o_rd = 1; o_addr = z_addr; o_sel = z_sel;
        if (rw > 0) rw--;
        else begin
          z_ack = 1'b1; z_data = line_of(z_addr); rd_ack_n = c;
        end
      end else if (z_wr_req) begin
        if (!o_wr) o_gap = c - rd_ack_n;
        o_wr = 1; o_wdata = z_wdata; z_ack = 1'b1;
        store_line(z_addr, z_wdata);
      end else if (in_ready) begin
        o_kind = 2; done = 1;
      end
      @(posedge clk); #1;
      z_ack = 1'b0; out_ready = 1'b0;
    end
    wbm_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (z_rd_req !== 1'b0 || z_wr_req !== 1'b0 || out_valid !== 1'b0) begin
      err++; $display("FAIL reset_req got rd=%b wr=%b ov=%b exp 0", z_rd_req, z_wr_req, out_valid);
    end
    vec++; if (z_sel !== 32'd0 || z_wdata !== '0 || z_addr !== '0) begin
      err++; $display("FAIL reset_bus got sel=%h addr=%h exp 0", z_sel, z_addr);
    end
    vec++; if (px_x !== 0 || px_a !== 0 || px_col !== 0 || px_z !== 0) begin
      err++; $display("FAIL reset_payload got x=%h a=%h exp 0", px_x, px_a);
    end
    vec++; if (clip_cnt !== 0 || zfail_cnt !== 0 || pass_cnt !== 0) begin
      err++; $display("FAIL reset_cnt got %0d %0d %0d exp 0", clip_cnt, zfail_cnt, pass_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (in_ready !== 1'b1) begin
      err++; $display("FAIL reset_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_raster();
    clip_en = 0; z_en = 0;
    setpix(1'b0, 5, 5, 3);
    run_pixel(0, 0);
    m_count(0);
    vec++; if (o_kind !== 1 || o_lat !== 1) begin
      err++; $display("FAIL raster_lat got kind=%0d lat=%0d exp 1/1", o_kind, o_lat);
    end
    vec++; if (o_a !== 8'hFF || o_z !== 16'd0) begin
      err++; $display("FAIL raster_az got a=%h z=%h exp ff/0", o_a, o_z);
    end
    vec++; if (o_rd !== 0 || o_x !== 16'd5 || o_y !== 16'd5 || o_col !== s_color) begin
      err++; $display("FAIL raster_payload got rd=%b x=%0d y=%0d col=%h", o_rd, o_x, o_y, o_col);
    end
  endtask

  task automatic test_clip_discard();
    clip_en = 1; cx0 = 10; cy0 = 10; cx1 = 20; cy1 = 20;
    setpix(1'b0, 20, 15, 0);
    run_pixel(0, 0);
    m_count(1);
    vec++; if (o_kind !== 2 || o_rdy_low !== 1) begin
      err++; $display("FAIL clip_drop got kind=%0d rdylow=%0d exp 2/1", o_kind, o_rdy_low);
    end
    vec++; if (clip_cnt !== CW'(m_clip) || pass_cnt !== CW'(m_pass)) begin
      err++; $display("FAIL clip_cnt got %0d/%0d exp %0d/%0d", clip_cnt, pass_cnt, m_clip, m_pass);
    end
    clip_en = 0;
  endtask

  task automatic test_z_pass();
    z_en = 1; z_wen = 0; z_func = 3'd1;
    zbuf[657] = 16'sd9;
    setpix(1'b1, 17, 1, 5);
    run_pixel(0, 0);
    m_count(0);
    vec++; if (o_addr !== 27'h100 + 27'd41 || o_sel !== 32'h0000000C) begin
      err++; $display("FAIL zpass_bus got addr=%h sel=%h exp 129/c", o_addr, o_sel);
    end
    vec++; if (o_kind !== 1 || o_lat !== 2 || o_z !== 16'd5 || o_a !== 8'(s_a)) begin
      err++; $display("FAIL zpass_out got kind=%0d lat=%0d z=%h a=%h", o_kind, o_lat, o_z, o_a);
    end
  endtask

  task automatic test_z_fail();
    z_func = 3'd4;
    setpix(1'b1, 17, 1, 5);
    run_pixel(1, 0);
    m_count(2);
    vec++; if (o_kind !== 2 || o_rd !== 1) begin
      err++; $display("FAIL zfail_drop got kind=%0d rd=%b exp 2/1", o_kind, o_rd);
    end
    vec++; if (zfail_cnt !== CW'(m_zfail)) begin
      err++; $display("FAIL zfail_cnt got %0d exp %0d", zfail_cnt, m_zfail);
    end
  endtask

  task automatic test_z_write_busy();
    logic [255:0] exp_line;
    z_func = 3'd1; z_wen = 1;
    exp_line = line_of(27'h129);
    exp_line[16 +: 16] = 16'h0005;
    setpix(1'b1, 17, 1, 5);
    run_pixel(0, 3);
    m_count(0);
    vec++; if (o_gap !== 4 || o_lat !== 6) begin
      err++; $display("FAIL zwr_busy got gap=%0d lat=%0d exp 4/6", o_gap, o_lat);
    end
    vec++; if (o_wdata !== exp_line) begin
      err++; $display("FAIL zwr_data got %h exp %h", o_wdata, exp_line);
    end
    z_wen = 0; z_en = 0;
  endtask

  task automatic test_random();
    int code, idx, rw, wb, elat;
    bit zt, wr;
    logic [255:0] eline;
    for (int i = 0; i < 60; i++) begin
      clip_en = 1'($urandom_range(0, 1));
      z_en = 1'($urandom_range(0, 1));
      z_wen = 1'($urandom_range(0, 1));
      z_func = 3'($urandom_range(0, 7));
      cx0 = 16'($urandom_range(0, 300)); cx1 = cx0 + 16'($urandom_range(0, 340));
      cy0 = 16'($urandom_range(0, 200)); cy1 = cy0 + 16'($urandom_range(0, 280));
      setpix(1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 640 : int'($urandom_range(0, 700)),
             ($urandom_range(0, 7) == 0) ? 480 : int'($urandom_range(0, 520)),
             int'($urandom_range(0, 16)) - 8);
      rw = int'($urandom_range(0, 2));
      wb = int'($urandom_range(0, 2));
      code = m_code();
      idx = s_y * 640 + s_x;
      zt = s_src && z_en && code != 1;
      wr = zt && code == 0 && z_wen;
      eline = line_of(zbase + 27'(idx / 16));
      eline[(idx % 16) * 16 +: 16] = 16'(s_z);
      elat = !zt ? 1 : (!wr ? 2 + rw : 3 + rw + wb);
      run_pixel(rw, wb);
      m_count(code);
      vec++; if (o_kind !== ((code == 0) ? 1 : 2) || o_rd !== zt || o_wr !== wr || o_both) begin
        err++; $display("FAIL rnd%0d_flow got kind=%0d rd=%b wr=%b both=%b exp code=%0d", i, o_kind, o_rd, o_wr, o_both, code);
      end
      if (code == 0) begin
        vec++; if (o_lat !== elat || o_x !== 16'(s_x) || o_y !== 16'(s_y) || o_u !== 16'(s_u) || o_v !== 16'(s_v) || o_col !== s_color) begin
          err++; $display("FAIL rnd%0d_out got lat=%0d x=%0d y=%0d exp lat=%0d x=%0d y=%0d", i, o_lat, o_x, o_y, elat, s_x, s_y);
        end
        vec++; if (o_a !== (s_src ? 8'(s_a) : 8'hFF) || o_z !== 16'(s_src ? s_z : 0)) begin
          err++; $display("FAIL rnd%0d_az got a=%h z=%h", i, o_a, o_z);
        end
      end
      if (zt) begin
        vec++; if (o_addr !== zbase + 27'(idx / 16) || o_sel !== (32'h3 << ((idx % 16) * 2))) begin
          err++; $display("FAIL rnd%0d_bus got addr=%h sel=%h idx=%0d", i, o_addr, o_sel, idx);
        end
      end
      if (wr) begin
        vec++; if (o_wdata !== eline) begin
          err++; $display("FAIL rnd%0d_wdata got %h exp %h", i, o_wdata, eline);
        end
      end
      vec++; if (clip_cnt !== CW'(m_clip) || zfail_cnt !== CW'(m_zfail) || pass_cnt !== CW'(m_pass)) begin
        err++; $display("FAIL rnd%0d_cnt got %0d/%0d/%0d exp %0d/%0d/%0d", i, clip_cnt, zfail_cnt, pass_cnt, m_clip, m_zfail, m_pass);
      end
    end
    clip_en = 0; z_en = 0; z_wen = 0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20 && m_pass < SAT; i++) begin
      setpix(1'b0, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 0);
      run_pixel(0, 0);
      m_count(0);
    end
    setpix(1'b0, 1, 1, 0);
    run_pixel(0, 0);
    m_count(0);
    vec++; if (pass_cnt !== 4'hF || m_pass != SAT) begin
      err++; $display("FAIL sat_pass got %0d exp 15", pass_cnt);
    end
  endtask

  task automatic test_clr_same_cycle();
    in_src = 1'b0; in_x = 16'd3; in_y = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; clr = 1'b0;
    m_clip = 0; m_zfail = 0; m_pass = 0;
    vec++; if (pass_cnt !== 0 || clip_cnt !== 0 || zfail_cnt !== 0) begin
      err++; $display("FAIL clr_prio got %0d/%0d/%0d exp 0", clip_cnt, zfail_cnt, pass_cnt);
    end
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err++; $display("FAIL clr_idle got rdy=%b ov=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_zrd();
    z_en = 1; z_func = 3'd7; clip_en = 0;
    in_src = 1'b1; in_x = 16'd30; in_y = 16'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vec++; if (z_rd_req !== 1'b1) begin
      err++; $display("FAIL rstzrd_req got %b exp 1", z_rd_req);
    end
    rst_n = 1'b0;
    #1;
    vec++; if (z_rd_req !== 1'b0 || z_wr_req !== 1'b0 || z_sel !== 32'd0) begin
      err++; $display("FAIL rstzrd_drop got rd=%b wr=%b sel=%h exp 0", z_rd_req, z_wr_req, z_sel);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err++; $display("FAIL rstzrd_idle got rdy=%b ov=%b exp 1/0", in_ready, out_valid);
    end
    z_en = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_raster();
    test_clip_discard();
    test_z_pass();
    test_z_fail();
    test_z_write_busy();
    test_random();
    test_saturate();
    test_clr_same_cycle();
    test_reset_mid_zrd();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
